des_decrypt_iter: RTL



---
 rtl/des_pkg.sv | 123 ++++++++++++
 rtl/des_feistel_f.sv | 23 ++
 rtl/des_decrypt_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES tables, permutation helpers and FSM state encoding for the DES datapath.
// Bit numbering follows DES: bit 1 is the MSB of each vector.
package des_pkg;

  typedef logic [1:0] des_state_t;
  localparam des_state_t ST_IDLE  = 2'd0;
  localparam des_state_t ST_ROUND = 2'd1;
  localparam des_state_t ST_DONE  = 2'd2;

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Indexed [box][row*16 + col]
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Right-rotate amount applied before each decrypt round; round 0 uses the unrotated C/D (K16)
  localparam logic [1:0] DEC_SHIFT [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[i])];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int unsigned i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[i])];
    return y;
  endfunction

  function automatic logic [55:0] des_pc1(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int unsigned i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_pc2(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    return y;
  endfunction

  function automatic logic [47:0] des_e(input logic [31:0] x);
    logic [47:0] y;
    y = '0;
    for (int unsigned i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[i])];
    return y;
  endfunction

  function automatic logic [31:0] des_p(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int unsigned i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[i])];
    return y;
  endfunction

  // Row from outer bits b1/b6, column from inner bits b2..b5
  function automatic logic [3:0] des_sbox(input logic [2:0] n, input logic [5:0] b);
    return SBOX[n][{b[5], b[0], b[4:1]}];
  endfunction

  function automatic logic [27:0] des_rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_feistel_f.sv
// Combinational DES round function f(R, K): E expansion, key mix, S-boxes, P.
// Shared between the encrypt and decrypt datapaths.
module des_feistel_f
  import des_pkg::*;
(
  input  logic [31:0] i_r,
  input  logic [47:0] i_k,
  output logic [31:0] o_f
);

  logic [47:0] w_x;
  logic [31:0] w_s;

  always_comb begin
    w_x = des_e(i_r) ^ i_k;
    w_s = '0;
    for (int unsigned j = 0; j < 8; j++) begin
      w_s = {w_s[27:0], des_sbox(3'(j), 6'(w_x >> (42 - 6 * j)))};
    end
    o_f = des_p(w_s);
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryptor: one Feistel round per clock with subkeys K16..K1.
// Define DES_DECRYPT_PARITY_CHK_EN to add the o_key_err key-parity flag.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_ciphertext,
  input  logic [63:0] i_key,
  input  logic        i_dv,
  output logic        o_ready,
  output logic [63:0] o_cleartext,
  output logic        o_dv,
  input  logic        i_ready
`ifdef DES_DECRYPT_PARITY_CHK_EN
  ,
  output logic        o_key_err
`endif
);

  des_state_t  r_state;
  logic [31:0] r_l, r_r;
  logic [27:0] r_c, r_d;
  logic [3:0]  r_round;

  logic [27:0] w_c_rot, w_d_rot;
  logic [47:0] w_subkey;
  logic [31:0] w_f, w_r_new;

  always_comb begin
    w_c_rot  = des_rotr28(r_c, DEC_SHIFT[r_round]);
    w_d_rot  = des_rotr28(r_d, DEC_SHIFT[r_round]);
    w_subkey = des_pc2({w_c_rot, w_d_rot});
  end

  des_feistel_f u_feistel (
    .i_r (r_r),
    .i_k (w_subkey),
    .o_f (w_f)
  );

  assign w_r_new = r_l ^ w_f;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_round     <= '0;
      o_ready     <= 1'b1;
      o_dv        <= 1'b0;
      o_cleartext <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_dv) begin
            {r_l, r_r} <= des_ip(i_ciphertext);
            {r_c, r_d} <= des_pc1(i_key);
            r_round    <= '0;
            o_ready    <= 1'b0;
            r_state    <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_c     <= w_c_rot;
          r_d     <= w_d_rot;
          r_l     <= r_r;
          r_r     <= w_r_new;
          r_round <= r_round + 4'd1;
          // Final swap folded in: FP sees {R16, L16}
          if (r_round == 4'd15) begin
            o_cleartext <= des_fp({w_r_new, r_r});
            o_dv        <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_dv    <= 1'b0;
            o_ready <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DES_DECRYPT_PARITY_CHK_EN
  logic r_key_err;
  logic w_par_err;

  // Each key byte must have odd parity
  always_comb begin
    w_par_err = 1'b0;
    for (int unsigned b = 0; b < 8; b++) begin
      if (!(^i_key[8 * b +: 8])) w_par_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key_err <= 1'b0;
    end else if (r_state == ST_IDLE && i_dv) begin
      r_key_err <= w_par_err;
    end
  end

  assign o_key_err = r_key_err & o_dv;
`endif

endmodule
